// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Round-robin arbiter that shares one external combinational ALU between
//   two requesters. Each cycle at most one request is granted. The winner's
//   operands drive the ALU. The ALU result is captured into that port's
//   response register, which holds its value under backpressure.
//
// Ports
//   Clk, Reset            clock, synchronous active-high reset
//   ReqValid/Ready/Op/A/B request handshake and operands, ports 0 and 1
//   RspValid/Ready/Data   response handshake and result, ports 0 and 1
//   AluOp/AluA/AluB       drive to the external ALU (zero when idle)
//   AluOut                result returned by the external ALU
//   Grant                 one-hot grant for this cycle (bit i = port i)
module alu_arbiter #(
  parameter int W   = 8,
  parameter int Ops = 4
) (
  input  logic           Clk,
  input  logic           Reset,

  input  logic           ReqValid0,
  output logic           ReqReady0,
  input  logic [Ops-1:0] ReqOp0,
  input  logic [W-1:0]   ReqA0,
  input  logic [W-1:0]   ReqB0,

  input  logic           ReqValid1,
  output logic           ReqReady1,
  input  logic [Ops-1:0] ReqOp1,
  input  logic [W-1:0]   ReqA1,
  input  logic [W-1:0]   ReqB1,

  output logic           RspValid0,
  input  logic           RspReady0,
  output logic [W-1:0]   RspData0,

  output logic           RspValid1,
  input  logic           RspReady1,
  output logic [W-1:0]   RspData1,

  output logic [Ops-1:0] AluOp,
  output logic [W-1:0]   AluA,
  output logic [W-1:0]   AluB,
  input  logic [W-1:0]   AluOut,

  output logic [1:0]     Grant
);

  // Index of the port that won the most recent grant. It resets to 1 so
  // that port 0 wins the first tie.
  logic last_grant;
  logic elig0;
  logic elig1;

  // A port may be granted only when its response slot is empty or is being
  // drained this cycle. Nothing is granted while Reset is high, because
  // the response registers are being cleared in that cycle.
  always_comb begin
    elig0 = !Reset && ReqValid0 && (!RspValid0 || RspReady0);
    elig1 = !Reset && ReqValid1 && (!RspValid1 || RspReady1);
    Grant = 2'b00;
    if (elig0 && elig1) begin
      Grant = last_grant ? 2'b01 : 2'b10;
    end else if (elig0) begin
      Grant = 2'b01;
    end else if (elig1) begin
      Grant = 2'b10;
    end
  end

  assign ReqReady0 = Grant[0];
  assign ReqReady1 = Grant[1];

  always_comb begin
    AluOp = '0;
    AluA  = '0;
    AluB  = '0;
    if (Grant[0]) begin
      AluOp = ReqOp0;
      AluA  = ReqA0;
      AluB  = ReqB0;
    end else if (Grant[1]) begin
      AluOp = ReqOp1;
      AluA  = ReqA1;
      AluB  = ReqB1;
    end
  end

  // A refill takes priority over a drain, so a slot that drains and is
  // re-granted in the same cycle keeps RspValid high with the new result.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      last_grant <= 1'b1;
      RspValid0  <= 1'b0;
      RspValid1  <= 1'b0;
      RspData0   <= '0;
      RspData1   <= '0;
    end else begin
      if (Grant != 2'b00) begin
        last_grant <= Grant[1];
      end

      if (Grant[0]) begin
        RspValid0 <= 1'b1;
        RspData0  <= AluOut;
      end else if (RspValid0 && RspReady0) begin
        RspValid0 <= 1'b0;
      end

      if (Grant[1]) begin
        RspValid1 <= 1'b1;
        RspData1  <= AluOut;
      end else if (RspValid1 && RspReady1) begin
        RspValid1 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
//   Directed bench for alu_arbiter with a small behavioural ALU attached.
//   Inputs are driven on the falling edge. Outputs are sampled 1 ns later,
//   so the registered outputs reflect the previous rising edge and the
//   combinational outputs reflect the freshly driven inputs.
module tb_alu_arbiter;

  localparam int W   = 8;
  localparam int Ops = 4;

  localparam logic [Ops-1:0] OP_ADD = 4'd0;
  localparam logic [Ops-1:0] OP_EQ  = 4'd1;
  localparam logic [Ops-1:0] OP_NEG = 4'd2;
  localparam logic [Ops-1:0] OP_LSH = 4'd3;
  localparam logic [Ops-1:0] OP_RSH = 4'd4;

  logic           clk;
  logic           reset;
  logic           req_valid0, req_valid1;
  logic           req_ready0, req_ready1;
  logic [Ops-1:0] req_op0, req_op1;
  logic [W-1:0]   req_a0, req_a1, req_b0, req_b1;
  logic           rsp_valid0, rsp_valid1;
  logic           rsp_ready0, rsp_ready1;
  logic [W-1:0]   rsp_data0, rsp_data1;
  logic [Ops-1:0] alu_op;
  logic [W-1:0]   alu_a, alu_b, alu_out;
  logic [1:0]     grant;

  int n_checks = 0;
  int n_errors = 0;

  alu_arbiter #(.W(W), .Ops(Ops)) dut (
    .Clk(clk), .Reset(reset),
    .ReqValid0(req_valid0), .ReqReady0(req_ready0), .ReqOp0(req_op0),
    .ReqA0(req_a0), .ReqB0(req_b0),
    .ReqValid1(req_valid1), .ReqReady1(req_ready1), .ReqOp1(req_op1),
    .ReqA1(req_a1), .ReqB1(req_b1),
    .RspValid0(rsp_valid0), .RspReady0(rsp_ready0), .RspData0(rsp_data0),
    .RspValid1(rsp_valid1), .RspReady1(rsp_ready1), .RspData1(rsp_data1),
    .AluOp(alu_op), .AluA(alu_a), .AluB(alu_b), .AluOut(alu_out),
    .Grant(grant)
  );

  // Behavioural stand-in for the shared ALU.
  always_comb begin
    alu_out = '0;
    case (alu_op)
      OP_ADD:  alu_out = alu_a + alu_b;
      OP_EQ:   alu_out = {7'd0, (alu_a == alu_b)};
      OP_NEG:  alu_out = -alu_a;
      OP_LSH:  alu_out = alu_a << 1;
      OP_RSH:  alu_out = alu_a >> 1;
      default: alu_out = '0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic req0(input logic v, input logic [Ops-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid0 = v; req_op0 = op; req_a0 = a; req_b0 = b;
  endtask

  task automatic req1(input logic v, input logic [Ops-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid1 = v; req_op1 = op; req_a1 = a; req_b1 = b;
  endtask

  // Move to the next falling edge; inputs are then driven before sample().
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic sample();
    #1;
  endtask

  initial begin
    reset = 1'b1;
    rsp_ready0 = 1'b0;
    rsp_ready1 = 1'b0;
    req0(1'b1, OP_ADD, 8'h25, 8'h1A);
    req1(1'b1, OP_ADD, 8'h01, 8'h01);

    // Reset held with both ports requesting.
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      sample();
      check("rst_req_ready0", 32'(req_ready0), 32'd0);
      check("rst_req_ready1", 32'(req_ready1), 32'd0);
      check("rst_rsp_valid0", 32'(rsp_valid0), 32'd0);
      check("rst_rsp_valid1", 32'(rsp_valid1), 32'd0);
      check("rst_rsp_data0",  32'(rsp_data0),  32'd0);
      check("rst_rsp_data1",  32'(rsp_data1),  32'd0);
    end

    // First cycle after release: the tie goes to port 0. This also issues
    // ADD 25+1A on port 0.
    next_cycle();
    reset = 1'b0;
    rsp_ready0 = 1'b1;
    rsp_ready1 = 1'b1;
    sample();
    check("first_tie_grant", 32'(grant), 32'h1);
    check("add_req_ready0",  32'(req_ready0), 32'd1);
    check("add_req_ready1",  32'(req_ready1), 32'd0);

    next_cycle();
    req0(1'b0, OP_ADD, 8'h00, 8'h00);
    req1(1'b0, OP_ADD, 8'h00, 8'h00);
    sample();
    check("add_rsp_valid0", 32'(rsp_valid0), 32'd1);
    check("add_rsp_data0",  32'(rsp_data0),  32'h3F);
    check("add_rsp_valid1", 32'(rsp_valid1), 32'd0);
    check("idle_grant",     32'(grant),      32'h0);
    check("idle_alu_a",     32'(alu_a),      32'h0);

    // Port 1 alone, so that port 1 holds LastGrant before the contention run.
    next_cycle();
    req1(1'b1, OP_ADD, 8'h01, 8'h01);
    sample();
    check("drain_rsp_valid0", 32'(rsp_valid0), 32'd0);
    check("solo1_grant",      32'(grant),      32'h2);
    check("solo1_alu_a",      32'(alu_a),      32'h01);

    // Contention over 4 cycles: EQ 10/10 on port 0, NEG 01 on port 1.
    next_cycle();
    req0(1'b1, OP_EQ, 8'h10, 8'h10);
    req1(1'b1, OP_NEG, 8'h01, 8'h00);
    sample();
    check("solo1_rsp_data1", 32'(rsp_data1), 32'h02);
    check("cont_grant_c0",   32'(grant),     32'h1);
    check("cont_alu_op_c0",  32'(alu_op),    32'(OP_EQ));

    next_cycle();
    sample();
    check("cont_grant_c1",     32'(grant),      32'h2);
    check("cont_req_ready1",   32'(req_ready1), 32'd1);
    check("cont_rsp_valid0_a", 32'(rsp_valid0), 32'd1);
    check("cont_rsp_data0_a",  32'(rsp_data0),  32'h01);

    next_cycle();
    sample();
    check("cont_grant_c2",     32'(grant),      32'h1);
    check("cont_rsp_valid1_a", 32'(rsp_valid1), 32'd1);
    check("cont_rsp_data1_a",  32'(rsp_data1),  32'hFF);

    next_cycle();
    sample();
    check("cont_grant_c3",    32'(grant),     32'h2);
    check("cont_rsp_data0_b", 32'(rsp_data0), 32'h01);

    // Backpressure: port 1 runs LSH 81, then stalls its consumer.
    next_cycle();
    req0(1'b0, OP_ADD, 8'h00, 8'h00);
    req1(1'b1, OP_LSH, 8'h81, 8'h00);
    sample();
    check("cont_rsp_data1_b", 32'(rsp_data1), 32'hFF);
    check("lsh_grant",        32'(grant),     32'h2);

    next_cycle();
    rsp_ready1 = 1'b0;
    req0(1'b1, OP_ADD, 8'h10, 8'h20);
    req1(1'b1, OP_ADD, 8'h03, 8'h04);
    for (int i = 0; i < 3; i++) begin
      sample();
      check("bp_rsp_data1",  32'(rsp_data1),  32'h02);
      check("bp_rsp_valid1", 32'(rsp_valid1), 32'd1);
      check("bp_req_ready1", 32'(req_ready1), 32'd0);
      check("bp_grant",      32'(grant),      32'h1);
      if (i > 0) check("bp_rsp_data0", 32'(rsp_data0), 32'h30);
      next_cycle();
    end

    // The stalled consumer takes its result. The pending port 1 request
    // wins because port 0 was granted last.
    rsp_ready1 = 1'b1;
    sample();
    check("release_grant",      32'(grant),      32'h2);
    check("release_req_ready1", 32'(req_ready1), 32'd1);

    next_cycle();
    rsp_ready1 = 1'b0;
    req0(1'b1, OP_ADD, 8'h01, 8'h02);
    req1(1'b0, OP_ADD, 8'h00, 8'h00);
    sample();
    check("release_rsp_data1",  32'(rsp_data1),  32'h07);
    check("release_rsp_valid1", 32'(rsp_valid1), 32'd1);
    check("release_rsp_valid0", 32'(rsp_valid0), 32'd0);

    // Drain and refill on port 0 with RSH 80.
    next_cycle();
    req0(1'b1, OP_RSH, 8'h80, 8'h00);
    sample();
    check("refill_rsp_data0_pre", 32'(rsp_data0), 32'h03);
    check("refill_grant",         32'(grant),     32'h1);
    check("refill_alu_a",         32'(alu_a),     32'h80);

    // Both slots full and stalled: nothing may be granted.
    next_cycle();
    rsp_ready0 = 1'b0;
    req0(1'b1, OP_ADD, 8'h02, 8'h02);
    req1(1'b1, OP_ADD, 8'h05, 8'h05);
    sample();
    check("refill_rsp_valid0", 32'(rsp_valid0), 32'd1);
    check("refill_rsp_data0",  32'(rsp_data0),  32'h40);
    check("stall_rsp_valid1",  32'(rsp_valid1), 32'd1);
    check("stall_grant",       32'(grant),      32'h0);
    check("stall_alu_op",      32'(alu_op),     32'h0);

    // Reset mid-flight with both responses held.
    next_cycle();
    reset = 1'b1;
    sample();
    check("midrst_req_ready0", 32'(req_ready0), 32'd0);
    check("midrst_req_ready1", 32'(req_ready1), 32'd0);

    next_cycle();
    reset = 1'b0;
    rsp_ready0 = 1'b1;
    rsp_ready1 = 1'b1;
    req0(1'b0, OP_ADD, 8'h00, 8'h00);
    req1(1'b0, OP_ADD, 8'h00, 8'h00);
    sample();
    check("midrst_rsp_valid0", 32'(rsp_valid0), 32'd0);
    check("midrst_rsp_valid1", 32'(rsp_valid1), 32'd0);
    check("midrst_rsp_data0",  32'(rsp_data0),  32'd0);
    check("midrst_rsp_data1",  32'(rsp_data1),  32'd0);

    // No stale delivery after release, and the tie priority is restored.
    next_cycle();
    req0(1'b1, OP_ADD, 8'h11, 8'h22);
    req1(1'b1, OP_ADD, 8'h01, 8'h01);
    sample();
    check("post_rst_rsp_valid0", 32'(rsp_valid0), 32'd0);
    check("post_rst_rsp_valid1", 32'(rsp_valid1), 32'd0);
    check("post_rst_tie_grant",  32'(grant),      32'h1);

    next_cycle();
    req0(1'b0, OP_ADD, 8'h00, 8'h00);
    req1(1'b0, OP_ADD, 8'h00, 8'h00);
    sample();
    check("post_rst_rsp_data0", 32'(rsp_data0), 32'h33);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port round-robin arbiter that shares a single combinational ALU between two requesters, such as the fetch/branch unit and the execute stage. Each port issues {op, A, B} with a valid/ready handshake. The arbiter grants at most one request per cycle and drives the shared ALU with the winner's operands. It captures the ALU result into that port's response register and returns it with a valid/ready handshake, holding it under backpressure. The ALU is instantiated beside this block, not inside it; opcodes are the `op_mne` values from package `definitions`.

## Interface
- W, 8, operand/result width
- Ops, 4, opcode width
- Clk  in  1  clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high
- ReqValid0, ReqValid1  in  1  port i presents a request
- ReqReady0, ReqReady1  out  1  port i request accepted this cycle (combinational)
- ReqOp0, ReqOp1  in  Ops  ALU opcode for port i
- ReqA0, ReqA1, ReqB0, ReqB1  in  W  operands for port i
- RspValid0, RspValid1  out  1  port i response register full
- RspReady0, RspReady1  in  1  port i consumer takes response
- RspData0, RspData1  out  W  port i result
- AluOp  out  Ops  to ALU OP
- AluA, AluB  out  W  to ALU InputA/InputB
- AluOut  in  W  from ALU Out
- Grant  out  2  one-hot grant this cycle, for debug/coverage (combinational)

## Operation
- **Eligibility.** Port i is eligible when `ReqValid_i && (!RspValid_i || RspReady_i)`, meaning its response slot is free or is draining this cycle.
- **Arbitration.**
  - Only one port eligible: that port is granted.
  - Both eligible: the port that is not `LastGrant` is granted.
  - Neither eligible: no grant.
- **Grant effects.**
  - `ReqReady_i = Grant[i]`; the non-granted port sees `ReqReady` low.
  - `LastGrant` updates only on a grant.
- **ALU drive.**
  - With a grant, `AluOp/AluA/AluB` carry the granted port's `ReqOp/ReqA/ReqB`.
  - With no grant, `AluOp/AluA/AluB` are driven to all zeros.
- **Response register, port i.**
  - Grant[i] set: `RspData_i <= AluOut` and `RspValid_i <= 1`.
  - Grant[i] clear and `RspValid_i && RspReady_i`: `RspValid_i <= 0`, and `RspData_i` holds its value.
  - Drain and refill in the same cycle: the new result wins, and `RspValid_i` stays 1.
- **Backpressure.** While `RspValid_i = 1` and `RspReady_i = 0`, `RspData_i` and `RspValid_i` are held stable and port i is never granted.
- **Data handling.** The arbiter does not inspect or transform data. Result width is W; any truncation or compare semantics (e.g. GEQ/EQ/NEQ giving 0/1) belong to the ALU.
- **Reset.**
  - `RspValid0/1 = 0`, `RspData0/1 = 0`, `LastGrant = 1`, so port 0 wins the first tie.
  - Reset mid-operation discards any held responses. Requests presented during the Reset cycle are not granted, and all `ReqReady` are 0 while Reset = 1.

## Timing
- Accept-to-response latency is 1 cycle: a request accepted in cycle N gives `RspValid_i = 1` in cycle N+1.
- Throughput is one ALU op per cycle across both ports.
- A single port whose consumer holds `RspReady = 1` sustains 1 op/cycle.
- Fairness: with both ports continuously eligible, grants alternate 0,1,0,1,… Neither port waits more than 1 cycle behind the other.
- The combinational path runs `ReqValid/RspReady` → `Grant` → `Alu*` → (external ALU) → `AluOut` → `RspData` register. There is no combinational path from `AluOut` to any output.
- `ReqReady` depends on `ReqValid` of both ports. Requesters must not make `ReqValid` depend on `ReqReady`.

## Test plan
1. **Reset values.** Assert Reset for 2 cycles with both ports requesting. Required: `ReqReady0/1 = 0`, `RspValid0/1 = 0` and `RspData0/1 = 0` throughout. The first cycle after release with both eligible gives `Grant = 01` (port 0).
2. **Single port, single op.** Port 0 sends ADD A=8'h25 B=8'h1A with the real ALU attached. Required: `ReqReady0 = 1` in cycle N, then `RspValid0 = 1` and `RspData0 = 8'h3F` in cycle N+1; `RspValid1` stays 0.
3. **Contention.** Both ports hold requests for 4 cycles with `RspReady = 1`: port 0 sends EQ 8'h10/8'h10, port 1 sends NEG A=8'h01. Required: grants 0,1,0,1; `RspData0 = 8'h01` and `RspData1 = 8'hFF`, each valid the cycle after its grant.
4. **Backpressure.** Port 1 completes LSH A=8'h81 (`RspData1 = 8'h02`), then holds `RspReady1 = 0` for 3 cycles with a second request pending. Required: data held at 8'h02 and `ReqReady1 = 0` for those 3 cycles, while port 0 is granted every cycle. On the cycle `RspReady1 = 1`, port 1 is granted and the new result appears the next cycle.
5. **Drain and refill.** Port 0 has `RspValid0 = 1`; in the same cycle `RspReady0 = 1` and a new RSH A=8'h80 is granted. Required: `RspValid0` stays 1 and `RspData0 = 8'h40` next cycle.
6. **Reset mid-flight.** Assert Reset while `RspValid0 = RspValid1 = 1` with `RspReady` low. Required: both valids are 0 the next cycle, and no stale data is delivered after release.
